cam_tag_alloc_controller: RTL and testbench

- Initiator-side controller for the tri-port register file's write and CAM ports.
- Accepts tag lookup-or-insert requests over a valid/ready handshake and issues a CAM search to the regfile.
- On a hit, returns the matching entry. On a miss, allocates an entry and writes the tag into it.
- Sits between a client such as a TLB, MSHR or tag table and one tri_port_regfile instance. The regfile read port is not used.

---
 rtl/cam_tag_alloc_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_cam_tag_alloc_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_tag_alloc_controller.sv
// -----------------------------------------------------------------------------
// cam_tag_alloc_controller
//
// Purpose:
//   Lookup-or-insert controller for the write and CAM ports of a tri-port
//   register file. A client hands in a tag over a valid/ready handshake. The
//   controller issues one CAM search. On a hit it returns the matching entry.
//   On a miss it allocates an entry and writes the tag into it. Allocation
//   takes the lowest free entry first. Once every entry is valid it evicts
//   round-robin. At most one request is in flight at a time.
//
// Parameters:
//   SINGLE_ENTRY_WIDTH_IN_BITS : tag width; must match the attached regfile
//   NUM_ENTRY                  : number of regfile entries (>= 2); width of
//                                every one-hot vector
//
// Ports:
//   clk_in                       in   clock, rising edge
//   reset_in                     in   synchronous active-low reset
//   flush_in                     in   (CAM_TAG_ALLOC_FLUSH_EN only) clears the
//                                     valid bitmap and round-robin pointer
//                                     while the controller is IDLE
//   request_valid_in             in   request valid
//   request_tag_in               in   tag to look up or insert
//   request_ready_out            out  controller idle, can accept a request
//   response_valid_out           out  response valid
//   response_hit_out             out  1 = tag was present, 0 = newly inserted
//   response_index_decoded_out   out  one-hot entry holding the tag
//   response_ready_in            in   client accepts the response
//   write_en_out                 out  regfile write enable
//   write_entry_addr_decoded_out out  regfile one-hot write address
//   write_entry_out              out  regfile write data
//   cam_en_out                   out  regfile CAM enable
//   cam_entry_out                out  regfile CAM search key
//   cam_result_decoded_in        in   regfile match vector, valid the cycle
//                                     after cam_en_out
//
// Optional feature macro: CAM_TAG_ALLOC_FLUSH_EN
// -----------------------------------------------------------------------------
module cam_tag_alloc_controller #(
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 8,
    parameter int NUM_ENTRY                  = 4
) (
    input  logic                                  clk_in,
    input  logic                                  reset_in,
`ifdef CAM_TAG_ALLOC_FLUSH_EN
    input  logic                                  flush_in,
`endif
    input  logic                                  request_valid_in,
    input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_tag_in,
    output logic                                  request_ready_out,
    output logic                                  response_valid_out,
    output logic                                  response_hit_out,
    output logic [NUM_ENTRY-1:0]                  response_index_decoded_out,
    input  logic                                  response_ready_in,
    output logic                                  write_en_out,
    output logic [NUM_ENTRY-1:0]                  write_entry_addr_decoded_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_out,
    output logic                                  cam_en_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] cam_entry_out,
    input  logic [NUM_ENTRY-1:0]                  cam_result_decoded_in
);

    localparam int W     = SINGLE_ENTRY_WIDTH_IN_BITS;
    localparam int N     = NUM_ENTRY;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [W-1:0]     tag_q,    tag_d;
    logic [N-1:0]     valid_q,  valid_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             hit_q,    hit_d;
    logic [N-1:0]     index_q,  index_d;

    // -------------------------------------------------------------------------
    // Match / victim selection
    // -------------------------------------------------------------------------
    logic [N-1:0] match_vec;
    logic [N-1:0] match_onehot;
    logic [N-1:0] free_vec;
    logic [N-1:0] free_onehot;
    logic [N-1:0] rr_onehot;
    logic [N-1:0] victim_onehot;
    logic         any_match;
    logic         any_free;
    logic         flush_req;

    // The regfile powers up with every entry at zero. Without this mask a
    // search for tag 0 would hit entries that were never written.
    assign match_vec = cam_result_decoded_in & valid_q;
    assign any_match = |match_vec;

    // x & -x keeps only the lowest set bit. That gives "lowest index wins"
    // among multiple matches, and "lowest free entry first" on allocation.
    assign match_onehot = match_vec & (~match_vec + N'(1));

    assign free_vec    = ~valid_q;
    assign any_free    = |free_vec;
    assign free_onehot = free_vec & (~free_vec + N'(1));

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rr_decode
            assign rr_onehot[gi] = (rr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    assign victim_onehot = any_free ? free_onehot : rr_onehot;

`ifdef CAM_TAG_ALLOC_FLUSH_EN
    assign flush_req = flush_in;
`else
    assign flush_req = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        hit_d    = hit_q;
        index_d  = index_q;

        request_ready_out            = 1'b0;
        response_valid_out           = 1'b0;
        response_hit_out             = 1'b0;
        response_index_decoded_out   = '0;
        write_en_out                 = 1'b0;
        write_entry_addr_decoded_out = '0;
        write_entry_out              = '0;
        cam_en_out                   = 1'b0;
        cam_entry_out                = '0;

        case (state_q)
            ST_IDLE: begin
                request_ready_out = 1'b1;
                // A flush wins over a request arriving on the same edge. The
                // client keeps its request up and it is taken next cycle.
                if (flush_req) begin
                    valid_d  = '0;
                    rr_ptr_d = '0;
                end else if (request_valid_in) begin
                    tag_d   = request_tag_in;
                    state_d = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                cam_en_out    = 1'b1;
                cam_entry_out = tag_q;
                state_d       = ST_WAIT;
            end

            ST_WAIT: begin
                // The regfile search result arrives in this cycle.
                if (any_match) begin
                    hit_d   = 1'b1;
                    index_d = match_onehot;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                write_en_out                 = 1'b1;
                write_entry_out              = tag_q;
                write_entry_addr_decoded_out = victim_onehot;
                valid_d                      = valid_q | victim_onehot;
                hit_d                        = 1'b0;
                index_d                      = victim_onehot;
                // The pointer moves only when a valid entry is overwritten.
                // While the table is filling, it stays where it is.
                if (!any_free) begin
                    if (rr_ptr_q == PTR_W'(N - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = rr_ptr_q + PTR_W'(1);
                    end
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                response_valid_out         = 1'b1;
                response_hit_out           = hit_q;
                response_index_decoded_out = index_q;
                if (response_ready_in) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q  <= ST_IDLE;
            tag_q    <= '0;
            valid_q  <= '0;
            rr_ptr_q <= '0;
            hit_q    <= 1'b0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            hit_q    <= hit_d;
            index_q  <= index_d;
        end
    end

endmodule

// File: tb/tb_cam_tag_alloc_controller.sv
// -----------------------------------------------------------------------------
// tb_cam_tag_alloc_controller
//
// Directed bench for cam_tag_alloc_controller (NUM_ENTRY = 4, 8-bit tags).
// A small behavioural regfile answers CAM searches one cycle after cam_en_out.
// Each request pushes its expected response (hit, index, latency) onto a
// scoreboard queue. The entry is popped and compared when the controller
// responds.
// Defining CAM_TAG_ALLOC_FLUSH_EN also exercises the flush port.
// -----------------------------------------------------------------------------
module tb_cam_tag_alloc_controller;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n;
`ifdef CAM_TAG_ALLOC_FLUSH_EN
    logic         flush;
`endif
    logic         request_valid;
    logic [W-1:0] request_tag;
    logic         request_ready;
    logic         response_valid;
    logic         response_hit;
    logic [N-1:0] response_index;
    logic         response_ready;
    logic         write_en;
    logic [N-1:0] write_addr;
    logic [W-1:0] write_data;
    logic         cam_en;
    logic [W-1:0] cam_key;
    logic [N-1:0] cam_result;

    always #5 clk = ~clk;

    cam_tag_alloc_controller #(
        .SINGLE_ENTRY_WIDTH_IN_BITS(W),
        .NUM_ENTRY(N)
    ) dut (
        .clk_in                       (clk),
        .reset_in                     (reset_n),
`ifdef CAM_TAG_ALLOC_FLUSH_EN
        .flush_in                     (flush),
`endif
        .request_valid_in             (request_valid),
        .request_tag_in               (request_tag),
        .request_ready_out            (request_ready),
        .response_valid_out           (response_valid),
        .response_hit_out             (response_hit),
        .response_index_decoded_out   (response_index),
        .response_ready_in            (response_ready),
        .write_en_out                 (write_en),
        .write_entry_addr_decoded_out (write_addr),
        .write_entry_out              (write_data),
        .cam_en_out                   (cam_en),
        .cam_entry_out                (cam_key),
        .cam_result_decoded_in        (cam_result)
    );

    // Behavioural regfile: write port plus a registered CAM search.
    logic [W-1:0] rf_mem [N];

    initial begin
        for (int i = 0; i < N; i++) rf_mem[i] = '0;
        cam_result = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (write_en && write_addr[i]) rf_mem[i] <= write_data;
            cam_result[i] <= cam_en && (rf_mem[i] == cam_key);
        end
    end

    // Scoreboard
    typedef struct {
        logic [W-1:0] tag;
        logic         hit;
        logic [N-1:0] idx;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},  {31'd0, request_ready}, 32'd1);
        check({pfx, "_resp_valid"}, {31'd0, response_valid}, 32'd0);
        check({pfx, "_resp_hit"},   {31'd0, response_hit}, 32'd0);
        check({pfx, "_resp_idx"},   {28'd0, response_index}, 32'd0);
        check({pfx, "_wr_en"},      {31'd0, write_en}, 32'd0);
        check({pfx, "_wr_addr"},    {28'd0, write_addr}, 32'd0);
        check({pfx, "_wr_data"},    {24'd0, write_data}, 32'd0);
        check({pfx, "_cam_en"},     {31'd0, cam_en}, 32'd0);
        check({pfx, "_cam_key"},    {24'd0, cam_key}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
    endtask

    // Issue one request, wait for its response, and compare it with the
    // scoreboard entry. stall = number of extra cycles response_ready is held
    // low. During those cycles a competing request is also offered.
    task automatic do_req(input logic [W-1:0] tag, input logic exp_hit,
                          input logic [N-1:0] exp_idx, input int stall);
        exp_t e;
        exp_t got;
        int guard;
        int cycles;
        int wr_cnt;
        logic [N-1:0] wr_addr;
        logic [W-1:0] wr_data;

        e.tag = tag; e.hit = exp_hit; e.idx = exp_idx; e.lat = exp_hit ? 3 : 4;
        sb.push_back(e);

        @(negedge clk);
        request_valid = 1'b1;
        request_tag   = tag;
        guard = 0;
        while (!request_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready", {31'd0, request_ready}, 32'd1);

        // The request is accepted on the next rising edge.
        @(negedge clk);
        request_valid = 1'b0;
        cycles  = 1;
        wr_cnt  = 0;
        wr_addr = '0;
        wr_data = '0;
        while (!response_valid && cycles < 20) begin
            if (write_en) begin
                wr_cnt++;
                wr_addr = write_addr;
                wr_data = write_data;
            end
            @(negedge clk);
            cycles++;
        end
        check("resp_valid", {31'd0, response_valid}, 32'd1);

        got = sb.pop_front();
        check("latency",  cycles, got.lat);
        check("resp_hit", {31'd0, response_hit}, {31'd0, got.hit});
        check("resp_idx", {28'd0, response_index}, {28'd0, got.idx});
        if (got.hit) begin
            check("hit_no_write", wr_cnt, 0);
        end else begin
            check("miss_write_cnt",  wr_cnt, 1);
            check("miss_write_addr", {28'd0, wr_addr}, {28'd0, got.idx});
            check("miss_write_data", {24'd0, wr_data}, {24'd0, got.tag});
        end

        for (int s = 0; s < stall; s++) begin
            request_valid = 1'b1;
            request_tag   = tag ^ 8'h5A;
            @(negedge clk);
            check("stall_valid",     {31'd0, response_valid}, 32'd1);
            check("stall_hit",       {31'd0, response_hit}, {31'd0, got.hit});
            check("stall_idx",       {28'd0, response_index}, {28'd0, got.idx});
            check("stall_req_ready", {31'd0, request_ready}, 32'd0);
        end
        request_valid  = 1'b0;
        response_ready = 1'b1;
        @(negedge clk);
        response_ready = 1'b0;
        check("back_idle_ready", {31'd0, request_ready}, 32'd1);
        check("back_idle_valid", {31'd0, response_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        reset_n        = 1'b0;
        request_valid  = 1'b0;
        request_tag    = '0;
        response_ready = 1'b0;
`ifdef CAM_TAG_ALLOC_FLUSH_EN
        flush          = 1'b0;
`endif
        do_reset();

        // Tag 0 must not hit the zero-initialised, never-written entries.
        do_req(8'h00, 1'b0, 4'b0001, 0);
        do_req(8'hF0, 1'b0, 4'b0010, 0);
        do_req(8'hF0, 1'b1, 4'b0010, 0);

        // Fill, then evict round-robin from entry 0.
        do_reset();
        do_req(8'h01, 1'b0, 4'b0001, 0);
        do_req(8'h02, 1'b0, 4'b0010, 0);
        do_req(8'h03, 1'b0, 4'b0100, 0);
        do_req(8'h04, 1'b0, 4'b1000, 0);
        do_req(8'h05, 1'b0, 4'b0001, 0);
        do_req(8'h06, 1'b0, 4'b0010, 0);
        do_req(8'h01, 1'b0, 4'b0100, 0);
        do_req(8'h04, 1'b1, 4'b1000, 0);
        do_req(8'h05, 1'b1, 4'b0001, 0);

        // Response back-pressure: 5 stalled cycles with a competing request.
        do_req(8'h06, 1'b1, 4'b0010, 5);
        do_req(8'h02, 1'b0, 4'b1000, 0);

        // Reset while the controller is in the WRITE cycle.
        @(negedge clk);
        request_valid = 1'b1;
        request_tag   = 8'h77;
        @(negedge clk);
        request_valid = 1'b0;
        guard = 0;
        while (!write_en && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("write_phase_seen", {31'd0, write_en}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_write_reset");
        reset_n = 1'b1;
        do_req(8'hAA, 1'b0, 4'b0001, 0);

        // Flush (if built in) against a plain re-lookup.
        do_reset();
        do_req(8'h11, 1'b0, 4'b0001, 0);
`ifdef CAM_TAG_ALLOC_FLUSH_EN
        @(negedge clk);
        flush         = 1'b1;
        request_valid = 1'b1;
        request_tag   = 8'h11;
        @(negedge clk);
        flush         = 1'b0;
        request_valid = 1'b0;
        check("flush_blocks_req_cam", {31'd0, cam_en}, 32'd0);
        check("flush_blocks_req_rdy", {31'd0, request_ready}, 32'd1);
        do_req(8'h11, 1'b0, 4'b0001, 0);
`else
        do_req(8'h11, 1'b1, 4'b0001, 0);
`endif

        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
